// File: rtl/amadeus_comp_pkg.sv
// Shared definitions for the output-map compressor/decompressor pair:
// word layout, unit geometry and the decoder state encoding.
package amadeus_comp_pkg;

   localparam int WORD_W         = 64;
   localparam int UNITS_PER_WORD = 5;
   localparam int UNIT_W         = 12;
   localparam int RUN_W          = 4;
   localparam int VAL_W          = 8;
   localparam int EOM_BIT        = 63;
   localparam int NUM_MSB        = 62;
   localparam int NUM_LSB        = 60;
   localparam int NUM_W          = 3;
   localparam int LANES          = 16;
   localparam int LANE_CNT_W     = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_DRAIN
   } dec_state_t;

   // Unit idx sits at bits [12*idx+11 : 12*idx]; indices past the last unit read as zero.
   function automatic logic [UNIT_W-1:0] word_unit(input logic [WORD_W-1:0] word,
                                                   input logic [NUM_W-1:0]  idx);
      logic [UNIT_W-1:0] u;
      case (idx)
         3'd0:    u = word[0*UNIT_W +: UNIT_W];
         3'd1:    u = word[1*UNIT_W +: UNIT_W];
         3'd2:    u = word[2*UNIT_W +: UNIT_W];
         3'd3:    u = word[3*UNIT_W +: UNIT_W];
         3'd4:    u = word[4*UNIT_W +: UNIT_W];
         default: u = '0;
      endcase
      return u;
   endfunction

endpackage

// File: rtl/decomp_byte_buffer.sv
// Circular byte FIFO with up-to-16-byte push and pop per cycle; the 16 oldest
// bytes are presented combinationally, lanes past the fill level read zero.
module decomp_byte_buffer
   import amadeus_comp_pkg::*;
#(
   parameter int DEPTH = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [LANE_CNT_W-1:0]           push_num,
   input  logic [LANES-1:0][VAL_W-1:0]     push_data,
   input  logic [LANE_CNT_W-1:0]           pop_num,
   output logic [LANES-1:0][VAL_W-1:0]     head_data,
   output logic [LANE_CNT_W-1:0]           head_num,
   output logic [$clog2(DEPTH):0]          count
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [VAL_W-1:0]            mem_reg [DEPTH];
   logic [AW-1:0]               wr_ptr_reg;
   logic [AW-1:0]               rd_ptr_reg;
   logic [CNT_W-1:0]            count_reg;
   logic [LANE_CNT_W-1:0]       pop_eff;
   logic [DEPTH-1:0][AW-1:0]    wr_off;

   assign count    = count_reg;
   assign head_num = (count_reg >= CNT_W'(LANES)) ? LANE_CNT_W'(LANES) : LANE_CNT_W'(count_reg);
   assign pop_eff  = (pop_num > head_num) ? head_num : pop_num;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_reg + AW'(push_num);
         rd_ptr_reg <= rd_ptr_reg + AW'(pop_eff);
         count_reg  <= count_reg + CNT_W'(push_num) - CNT_W'(pop_eff);
      end
   end

   // Each entry knows its distance from the write pointer, so it can pick its own push lane.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_off
      assign wr_off[gi] = AW'(gi) - wr_ptr_reg;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (CNT_W'(wr_off[i]) < CNT_W'(push_num)) begin
            mem_reg[i] <= push_data[wr_off[i][3:0]];
         end
      end
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [AW-1:0] rd_idx;
      assign rd_idx        = rd_ptr_reg + AW'(gi);
      assign head_data[gi] = (LANE_CNT_W'(gi) < head_num) ? mem_reg[rd_idx] : '0;
   end

endmodule

// File: rtl/outmap_decompressor.sv
// Expands run-length coded 64-bit words into a byte stream for the output map.
// Define DECOMP_FMT_CHECK_EN to flag malformed unit counts on err.
module outmap_decompressor
   import amadeus_comp_pkg::*;
#(
   parameter int BUF_DEPTH = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   output logic                            mem_req,
   input  logic                            mem_valid,
   input  logic [WORD_W-1:0]               mem_data,
   output logic [LANES-1:0][VAL_W-1:0]     outmap_data,
   output logic [LANE_CNT_W-1:0]           outmap_data_valid_num,
   input  logic [LANE_CNT_W-1:0]           taken_num,
   output logic                            done,
   output logic                            err
);
   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   dec_state_t                    state_reg, state_next;
   logic [WORD_W-1:0]             word_reg;
   logic [NUM_W-1:0]              unit_idx_reg;
   logic [CNT_W-1:0]              count;
   logic [NUM_W-1:0]              num_raw, num_eff;
   logic                          eom, fmt_bad, last_unit, space_ok, unit_fire;
   logic [UNIT_W-1:0]             unit_cur;
   logic [RUN_W-1:0]              run_len;
   logic [VAL_W-1:0]              unit_val;
   logic [LANE_CNT_W-1:0]         run_plus1;
   logic [LANE_CNT_W-1:0]         push_num;
   logic [LANES-1:0][VAL_W-1:0]   push_data;

   assign eom     = word_reg[EOM_BIT];
   assign num_raw = word_reg[NUM_MSB:NUM_LSB];

`ifdef DECOMP_FMT_CHECK_EN
   logic err_reg;
   assign fmt_bad = (num_raw == '0) || (num_raw > NUM_W'(UNITS_PER_WORD));
   assign num_eff = num_raw;
   assign err     = err_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else if (state_reg == ST_DECODE && fmt_bad) begin
         err_reg <= 1'b1;
      end
   end
`else
   assign fmt_bad = 1'b0;
   assign num_eff = (num_raw > NUM_W'(UNITS_PER_WORD)) ? NUM_W'(UNITS_PER_WORD) : num_raw;
   assign err     = 1'b0;
`endif

   assign unit_cur  = word_unit(word_reg, unit_idx_reg);
   assign run_len   = unit_cur[UNIT_W-1 -: RUN_W];
   assign unit_val  = unit_cur[VAL_W-1:0];
   assign run_plus1 = {1'b0, run_len} + LANE_CNT_W'(1);
   // Space is judged on the fill level before this cycle's pop, so pop never feeds push.
   assign space_ok  = (CNT_W'(BUF_DEPTH) - count) >= CNT_W'(run_plus1);
   assign last_unit = (unit_idx_reg == num_eff - NUM_W'(1));
   assign unit_fire = (state_reg == ST_DECODE) && !fmt_bad && (num_eff != '0) && space_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (start) state_next = ST_FETCH;
         ST_FETCH:  if (mem_valid) state_next = ST_DECODE;
         ST_DECODE: begin
            if (fmt_bad) begin
               state_next = ST_DRAIN;
            end else if (num_eff == '0 || (space_ok && last_unit)) begin
               state_next = eom ? ST_DRAIN : ST_FETCH;
            end
         end
         ST_DRAIN:  if (count == '0) state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_req  = 1'b0;
      done     = 1'b0;
      push_num = '0;
      case (state_reg)
         ST_FETCH:  mem_req = 1'b1;
         ST_DECODE: if (unit_fire) push_num = run_plus1;
         ST_DRAIN:  done = (count == '0);
         default:   ;
      endcase
   end

   // A unit becomes R zero lanes followed by its value in lane R.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_push
      assign push_data[gi] = (RUN_W'(gi) == run_len) ? unit_val : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_reg     <= '0;
         unit_idx_reg <= '0;
      end else if (state_reg == ST_FETCH && mem_valid) begin
         word_reg     <= mem_data;
         unit_idx_reg <= '0;
      end else if (unit_fire) begin
         unit_idx_reg <= unit_idx_reg + NUM_W'(1);
      end
   end

   decomp_byte_buffer #(
      .DEPTH(BUF_DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push_num  (push_num),
      .push_data (push_data),
      .pop_num   (taken_num),
      .head_data (outmap_data),
      .head_num  (outmap_data_valid_num),
      .count     (count)
   );

endmodule

// File: tb/tb_outmap_decompressor.sv
// Directed bench for outmap_decompressor: a byte-stream model checks the
// output lanes every cycle, literal checks pin latency, stalls and control.
`timescale 1ns/1ps
module tb_outmap_decompressor;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              mem_req;
   logic              mem_valid = 1'b0;
   logic [63:0]       mem_data = '0;
   logic [15:0][7:0]  outmap_data;
   logic [4:0]        outmap_data_valid_num;
   logic [4:0]        taken_num = '0;
   logic              done;
   logic              err;

   int   vectors = 0;
   int   miscompares = 0;
   bit   chk_en = 1'b0;

   logic [63:0] word_q[$];
   logic [7:0]  exp_bytes[$];

   logic [4:0]       s_valid;
   logic             s_req, s_done, s_err;
   logic [15:0][7:0] s_data;

   always #5 clk = ~clk;

   outmap_decompressor #(.BUF_DEPTH(32)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .start                 (start),
      .mem_req               (mem_req),
      .mem_valid             (mem_valid),
      .mem_data              (mem_data),
      .outmap_data           (outmap_data),
      .outmap_data_valid_num (outmap_data_valid_num),
      .taken_num             (taken_num),
      .done                  (done),
      .err                   (err)
   );

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Queue a word for the memory responder and append its expansion to the expected stream.
   function automatic void add_word(input logic [63:0] w);
      int n;
      logic [11:0] u;
      word_q.push_back(w);
      n = int'(w[62:60]);
`ifdef DECOMP_FMT_CHECK_EN
      if (n == 0 || n > 5) n = 0;
`else
      if (n > 5) n = 5;
`endif
      for (int i = 0; i < n; i++) begin
         u = w[12*i +: 12];
         for (int z = 0; z < int'(u[11:8]); z++) exp_bytes.push_back(8'h00);
         exp_bytes.push_back(u[7:0]);
      end
   endfunction

   task automatic model_compare();
      logic [15:0][7:0] exp_l;
      int v;
      bit ok;
      v  = int'(outmap_data_valid_num);
      ok = (v <= 16) && (v <= exp_bytes.size());
      chk("valid_bound", int'(ok), 1);
      exp_l = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < v && i < exp_bytes.size()) exp_l[i] = exp_bytes[i];
      end
      chk_w("lane_stream", outmap_data, exp_l);
   endtask

   // One clock: respond to mem_req, sample/check at negedge, retire pops after posedge.
   task automatic step();
      int v, pop_n;
      logic acc, r;
      @(negedge clk);
      if (mem_req && word_q.size() > 0) begin
         mem_valid = 1'b1;
         mem_data  = word_q[0];
      end else begin
         mem_valid = 1'b0;
         mem_data  = '0;
      end
      s_valid = outmap_data_valid_num;
      s_req   = mem_req;
      s_done  = done;
      s_err   = err;
      s_data  = outmap_data;
      if (chk_en) model_compare();
      v     = int'(outmap_data_valid_num);
      pop_n = (int'(taken_num) < v) ? int'(taken_num) : v;
      acc   = mem_req && mem_valid;
      r     = rst;
      @(posedge clk);
      #1;
      if (r) begin
         exp_bytes.delete();
         word_q.delete();
      end else begin
         for (int i = 0; i < pop_n; i++) begin
            if (exp_bytes.size() > 0) void'(exp_bytes.pop_front());
         end
         if (acc && word_q.size() > 0) void'(word_q.pop_front());
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic start_map();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_req(input string name);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!s_req && n < 20);
      chk({name, "_seen"}, int'(s_req), 1);
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!s_done && n < budget);
      chk({name, "_seen"}, int'(s_done), 1);
   endtask

   task automatic wait_valid(input int target, input string name);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (int'(s_valid) != target && n < 20);
      chk(name, int'(s_valid), target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int gap;

      // Reset state.
      do_reset();
      chk_en = 1'b1;
      chk("rst_valid_num", int'(s_valid), 0);
      chk("rst_mem_req", int'(s_req), 0);
      chk("rst_done", int'(s_done), 0);
      chk("rst_err", int'(s_err), 0);
      chk_w("rst_data", s_data, 128'h0);

      // Single unit R=3 V=7F, then pop 4 to finish the map.
      add_word(64'h9000_0000_0000_037F);
      start_map();
      wait_req("t1_fetch");
      step();
      chk("t1_req_fall", int'(s_req), 0);
      chk("t1_valid_k1", int'(s_valid), 0);
      step();
      chk("t1_valid_k2", int'(s_valid), 4);
      chk_w("t1_lanes", s_data, 128'h7F00_0000);
      repeat (3) step();
      chk("t1_hold", int'({s_done, s_valid}), 4);
      taken_num = 5'd4;
      step();
      taken_num = 5'd0;
      step();
      chk("t1_done", int'(s_done), 1);
      chk("t1_valid_after", int'(s_valid), 0);
      step();
      chk("t1_done_pulse", int'(s_done), 0);

      // Five R=15 units: buffer fills after two, resumes only as space opens.
      add_word({4'hD, 12'hFA5, 12'hFA4, 12'hFA3, 12'hFA2, 12'hFA1});
      start_map();
      wait_req("t2_fetch");
      repeat (6) step();
      chk("t2_full_valid", int'(s_valid), 16);
      chk("t2_full_lane15", int'(s_data[15]), 8'hA1);
      taken_num = 5'd16;
      step();
      taken_num = 5'd0;
      step();
      chk("t2_pop1_lane15", int'(s_data[15]), 8'hA2);
      step();
      chk("t2_refill_valid", int'(s_valid), 16);
      taken_num = 5'd16;
      step();
      taken_num = 5'd0;
      step();
      chk("t2_pop2_lane15", int'(s_data[15]), 8'hA3);
      taken_num = 5'd16;
      wait_done("t2_done", 40);
      taken_num = 5'd0;

      // Two words across a word boundary.
      add_word({4'h5, 12'h005, 12'h004, 12'h003, 12'h002, 12'h001});
      add_word({4'hA, 36'h0, 12'h007, 12'h106});
      start_map();
      wait_req("t3_fetch1");
      gap = 0;
      do begin
         step();
         gap++;
      end while (!s_req && gap < 20);
      chk("t3_req_gap", gap, 6);
      chk("t3_valid_at_refetch", int'(s_valid), 5);
      wait_valid(8, "t3_fill");
      chk_w("t3_lanes", 128'(s_data[7:0]), 128'h0706_0005_0403_0201);
      taken_num = 5'd8;
      wait_done("t3_done", 20);
      taken_num = 5'd0;

      // Oversized taken_num is clamped to the visible byte count.
      add_word({4'hA, 36'h0, 12'hF22, 12'hF11});
      start_map();
      wait_req("t4_fetch");
      repeat (3) step();
      chk("t4_valid", int'(s_valid), 16);
      taken_num = 5'd20;
      step();
      taken_num = 5'd0;
      step();
      chk("t4_clamp_lane15", int'(s_data[15]), 8'h22);
      chk("t4_clamp_valid", int'(s_valid), 16);
      taken_num = 5'd20;
      step();
      step();
      chk("t4_done", int'(s_done), 1);
      step();
      step();
      chk("t4_no_underflow", int'(s_valid), 0);
      taken_num = 5'd0;

      // Reset mid-decode with 10 bytes buffered.
      add_word({4'hB, 24'h0, 12'hF55, 12'h444, 12'h433});
      start_map();
      wait_req("t5_fetch");
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_pre_rst_valid", int'(s_valid), 10);
      step();
      chk("t5_rst_valid", int'(s_valid), 0);
      chk("t5_rst_req", int'(s_req), 0);
      chk_w("t5_rst_data", s_data, 128'h0);
      repeat (3) step();
      chk("t5_idle", int'({s_done, s_req, s_valid}), 0);

      // Word with N=0.
      add_word(64'h0);
`ifndef DECOMP_FMT_CHECK_EN
      add_word({4'h9, 48'h0, 12'h099});
`endif
      start_map();
      wait_req("t6_fetch");
`ifdef DECOMP_FMT_CHECK_EN
      step();
      chk("t6_err_pre", int'(s_err), 0);
      step();
      chk("t6_err", int'(s_err), 1);
      chk("t6_done", int'(s_done), 1);
      chk("t6_no_refetch", int'(s_req), 0);
      repeat (2) step();
      chk("t6_err_sticky", int'(s_err), 1);
      do_reset();
      chk("t6_err_clear", int'(s_err), 0);
`else
      gap = 0;
      do begin
         step();
         gap++;
      end while (!s_req && gap < 20);
      chk("t6_skip_gap", gap, 2);
      chk("t6_err_tied", int'(s_err), 0);
      step();
      step();
      chk("t6_valid", int'(s_valid), 1);
      chk("t6_lane0", int'(s_data[0]), 8'h99);
      taken_num = 5'd1;
      wait_done("t6_done", 10);
      taken_num = 5'd0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/outmap_decompressor.md
OUTMAP_DECOMPRESSOR -- requirements
Module: outmap_decompressor

Interface
REQ-001 Parameter BUF_DEPTH, default 32, meaning byte-buffer depth; SHALL be a power of two and at least 32.
REQ-002 Port clk, input, 1, meaning the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1, meaning reset; SHALL be synchronous and active-high.
REQ-004 Port start, input, 1, meaning begin decoding one output map; SHALL be honoured only in IDLE.
REQ-005 Port mem_req, output, 1, meaning a compressed word is requested.
REQ-006 Port mem_valid, input, 1, meaning mem_data is valid; SHALL be ignored outside FETCH.
REQ-007 Port mem_data, input, 64, meaning compressed word.
REQ-008 Port outmap_data, output, [15:0][7:0], meaning the 16 oldest buffered bytes, head in lane 0.
REQ-009 Port outmap_data_valid_num, output, 5, meaning min(buffer count, 16).
REQ-010 Port taken_num, input, 5, meaning bytes popped by the consumer this cycle.
REQ-011 Port done, output, 1, meaning a one-cycle pulse at map completion.
REQ-012 Port err, output, 1, meaning sticky format error (see REQ-030).

Function
REQ-013 Word format SHALL be: [63] end-of-map (eom); [62:60] unit count N (1..5); unit i at bits [12i+11:12i]; each unit is [11:8] zero run R (0..15) and [7:0] value V.
REQ-014 Unit expansion SHALL append R zero bytes, then V (R+1 bytes); V=0 SHALL be legal.
REQ-015 FSM states SHALL be IDLE, FETCH, DECODE, DRAIN.
REQ-016 IDLE transitions to FETCH when start=1.
REQ-017 FETCH: mem_req=1; on mem_valid=1, latch the word, set unit index=0, go to DECODE.
REQ-018 DECODE: at most one unit expanded per cycle, in index order, only if free space (BUF_DEPTH minus count before this cycle's pop) is at least R+1; otherwise stall.
REQ-019 After unit N-1: if eom=0 go to FETCH, else go to DRAIN.
REQ-020 DRAIN: when count=0, pulse done for one cycle and go to IDLE.
REQ-021 Pop SHALL be min(taken_num, outmap_data_valid_num); an excess taken_num SHALL be clamped.
REQ-022 Push and pop in the same cycle SHALL both take effect; count_next = count + pushed - popped.
REQ-023 Buffer indices SHALL wrap modulo BUF_DEPTH.
REQ-024 Latency: word accepted at edge k; unit 0 bytes SHALL be visible on outmap_data at cycle k+2.
REQ-025 Lanes at or above outmap_data_valid_num SHALL read 0.
REQ-026 start outside IDLE SHALL be ignored.
REQ-027 mem_req SHALL fall in the cycle after mem_valid is accepted.

Reset
REQ-028 On rst: state=IDLE, count=0, pointers=0, mem_req=0, done=0, err=0, outmap_data=0, outmap_data_valid_num=0.
REQ-029 rst mid-map SHALL discard the buffered bytes and the latched word; no done pulse follows.

Configuration
REQ-030 With macro DECOMP_FMT_CHECK_EN defined, a word with N=0 or N>5 SHALL set err, expand no units, and be treated as eom=1; err clears only on rst.
REQ-031 Without DECOMP_FMT_CHECK_EN, err SHALL be tied 0, N=0 SHALL skip the word (eom still honoured), and N=6 or N=7 SHALL decode as 5.

Structure
REQ-032 Package amadeus_comp_pkg SHALL hold: UNITS_PER_WORD=5, UNIT_W=12, RUN_W=4, header bit positions, and the FSM state enum; the package is shared with the compressor.
REQ-033 The byte buffer SHALL be sub-module decomp_byte_buffer: multi-byte push (up to 16), multi-byte pop (up to 16), count output.

Verification
REQ-034 Bench SHALL cover: word {eom=1, N=1, R=3, V=0x7F}, taken_num=0 -> outmap_data_valid_num=4, lanes 0..3 = 00,00,00,7F; then taken_num=4 -> done pulses.
REQ-035 Bench SHALL cover: 5 units with R=15, taken_num=0 -> stalls after 2 units (count=32); taken_num=16 -> resumes.
REQ-036 Bench SHALL cover: two words, first eom=0 -> mem_req reasserts after 5 units; byte order is preserved across the word boundary.
REQ-037 Bench SHALL cover: taken_num=20 with 16 valid -> exactly 16 popped; count never underflows.
REQ-038 Bench SHALL cover: rst asserted in DECODE with 10 bytes buffered -> next cycle valid_num=0, mem_req=0, IDLE.
REQ-039 Bench SHALL cover: N=0 with the macro defined -> err=1, DRAIN, done; without the macro -> word skipped, FETCH repeats.
